// File: rtl/axis_cfg_scheduler.sv
// -----------------------------------------------------------------------------
// axis_cfg_scheduler
//
// Purpose:
//   Watches CHANNELS configuration words. Each changed word is marked
//   pending, and pending channels are sent one at a time on a single
//   AXI4-Stream master. Each beat carries {channel index, data}. Channels
//   are picked round-robin. A channel that already has an unsent update
//   only ever sends its latest value.
//
// Ports:
//   aclk           clock
//   aresetn        synchronous, active-low reset
//   cfg_data       packed config words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cfg_mask       1 = channel may be granted, 0 = updates are held pending
//   m_axis_tready  downstream ready
//   m_axis_tdata   {zeros, index[7:0], data[DATA_WIDTH-1:0]}
//   m_axis_tvalid  beat valid
//   m_axis_tlast   (only with AXIS_CFG_SCHEDULER_TLAST_EN) marks the last
//                  eligible channel at grant time
//   sts_pending    registered pending flags
//
// Build option:
//   AXIS_CFG_SCHEDULER_TLAST_EN adds the m_axis_tlast output port.
// -----------------------------------------------------------------------------
module axis_cfg_scheduler #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int DATA_WIDTH       = 24,
  parameter int CHANNELS         = 4,
  parameter int INDEX_WIDTH      = 2
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [CHANNELS*DATA_WIDTH-1:0] cfg_data,
  input  logic [CHANNELS-1:0]            cfg_mask,
  input  logic                           m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]    m_axis_tdata,
  output logic                           m_axis_tvalid,
`ifdef AXIS_CFG_SCHEDULER_TLAST_EN
  output logic                           m_axis_tlast,
`endif
  output logic [CHANNELS-1:0]            sts_pending
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_e;

  localparam logic [INDEX_WIDTH:0]   NUM_CH  = (INDEX_WIDTH+1)'(CHANNELS);
  localparam logic [INDEX_WIDTH-1:0] LAST_CH = INDEX_WIDTH'(CHANNELS - 1);

  state_e                          state_q, state_d;
  logic [CHANNELS*DATA_WIDTH-1:0]  shadow_q;
  logic [CHANNELS-1:0]             pending_q, pending_d;
  logic [INDEX_WIDTH-1:0]          rr_ptr_q, rr_ptr_d;
  logic [AXIS_TDATA_WIDTH-1:0]     tdata_q, tdata_d;

  logic [CHANNELS-1:0]             change;
  logic [CHANNELS-1:0]             eligible;
  logic [CHANNELS-1:0]             grant;
  logic                            grant_found;
  logic [INDEX_WIDTH-1:0]          grant_idx;
  logic [INDEX_WIDTH:0]            cand_sum;
  logic                            out_free;
  logic                            load;

`ifdef AXIS_CFG_SCHEDULER_TLAST_EN
  logic                            tlast_q, tlast_d;
`endif

  // A change is any difference between the live word and last cycle's copy.
  always_comb begin
    change = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      change[i] = (cfg_data[i*DATA_WIDTH +: DATA_WIDTH] != shadow_q[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Only registered pending flags compete. A change seen in the same cycle
  // has to wait one cycle before it can be granted.
  assign eligible = pending_q & cfg_mask;
  assign out_free = (state_q == IDLE) | m_axis_tready;

  // Round-robin search upward from rr_ptr_q, wrapping at CHANNELS.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    for (int off = 0; off < CHANNELS; off++) begin
      cand_sum = {1'b0, rr_ptr_q} + (INDEX_WIDTH+1)'(off);
      if (cand_sum >= NUM_CH) begin
        cand_sum = cand_sum - NUM_CH;
      end
      if (!grant_found && eligible[cand_sum[INDEX_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_sum[INDEX_WIDTH-1:0];
      end
    end
  end

  // Control FSM. The output register loads whenever it is free and some
  // channel is eligible. Otherwise it holds, so data stays stable under
  // backpressure.
  always_comb begin
    state_d  = state_q;
    tdata_d  = tdata_q;
    rr_ptr_d = rr_ptr_q;
    grant    = '0;
    load     = 1'b0;
`ifdef AXIS_CFG_SCHEDULER_TLAST_EN
    tlast_d  = tlast_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          load    = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (m_axis_tready) begin
          if (grant_found) begin
            load    = 1'b1;
            state_d = VALID;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load && out_free) begin
      grant[grant_idx]            = 1'b1;
      tdata_d                     = '0;
      tdata_d[DATA_WIDTH-1:0]     = shadow_q[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      tdata_d[DATA_WIDTH +: 8]    = 8'(grant_idx);
      rr_ptr_d                    = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
`ifdef AXIS_CFG_SCHEDULER_TLAST_EN
      tlast_d                     = $onehot(eligible);
`endif
    end
  end

  // A change on the same cycle as this channel's grant re-arms it, so the
  // newer value is sent later and no update is lost.
  assign pending_d = (pending_q & ~grant) | change;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      pending_q <= '0;
      rr_ptr_q <= '0;
      tdata_q  <= '0;
`ifdef AXIS_CFG_SCHEDULER_TLAST_EN
      tlast_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= cfg_data;
      pending_q <= pending_d;
      rr_ptr_q <= rr_ptr_d;
      tdata_q  <= tdata_d;
`ifdef AXIS_CFG_SCHEDULER_TLAST_EN
      tlast_q  <= tlast_d;
`endif
    end
  end

  assign m_axis_tvalid = (state_q == VALID);
  assign m_axis_tdata  = tdata_q;
  assign sts_pending   = pending_q;
`ifdef AXIS_CFG_SCHEDULER_TLAST_EN
  assign m_axis_tlast  = tlast_q;
`endif

endmodule

// File: tb/tb_axis_cfg_scheduler.sv
// -----------------------------------------------------------------------------
// tb_axis_cfg_scheduler
//
// Directed bench for axis_cfg_scheduler with default parameters (4 channels,
// 24-bit words, 32-bit stream). Expected beats are pushed to a scoreboard
// queue when a config word is driven. They are popped and compared when the
// stream presents a beat. Outputs are sampled and inputs are driven on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_axis_cfg_scheduler;

  logic        aclk;
  logic        aresetn;
  logic [95:0] cfgData;
  logic [3:0]  cfgMask;
  logic        tready;
  logic [31:0] tdata;
  logic        tvalid;
  logic [3:0]  stsPending;
`ifdef AXIS_CFG_SCHEDULER_TLAST_EN
  logic        tlast;
`endif

  logic [31:0] expQ[$];
  int          passCount;
  int          totalCount;

  axis_cfg_scheduler #(
    .AXIS_TDATA_WIDTH(32),
    .DATA_WIDTH      (24),
    .CHANNELS        (4),
    .INDEX_WIDTH     (2)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_data     (cfgData),
    .cfg_mask     (cfgMask),
    .m_axis_tready(tready),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
`ifdef AXIS_CFG_SCHEDULER_TLAST_EN
    .m_axis_tlast (tlast),
`endif
    .sts_pending  (stsPending)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Advance to the next falling edge, where outputs are stable.
  task automatic tick();
    @(negedge aclk);
  endtask

  // One comparison: count it, then assert equality.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Drive one channel's word and, if a beat is expected from it, push that
  // beat to the scoreboard.
  task automatic applyStimulus(input int ch, input logic [23:0] value, input bit expectBeat);
    logic [7:0] idx;
    idx = 8'(ch);
    cfgData[ch*24 +: 24] = value;
    if (expectBeat) expQ.push_back({idx, value});
  endtask

  // The beat presented right now must match the scoreboard head. Called
  // only while tready is high, so the beat handshakes at the next edge.
  task automatic expectBeatNow(input string tag);
    logic [31:0] exp;
    checkOutput({tag, "_valid"}, {31'b0, tvalid}, 32'd1);
    if (expQ.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, 32'd0, 32'd1);
    end else begin
      exp = expQ.pop_front();
      checkOutput({tag, "_data"}, tdata, exp);
    end
  endtask

  initial begin
    passCount  = 0;
    totalCount = 0;
    aresetn    = 1'b0;
    cfgData    = '0;
    cfgMask    = 4'hF;
    tready     = 1'b1;

    // Reset state and quiet idle with unchanged words.
    repeat (3) tick();
    checkOutput("rst_valid",   {31'b0, tvalid}, 32'd0);
    checkOutput("rst_tdata",   tdata, 32'd0);
    checkOutput("rst_pending", {28'b0, stsPending}, 32'd0);
    aresetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checkOutput("idle_valid",   {31'b0, tvalid}, 32'd0);
      checkOutput("idle_pending", {28'b0, stsPending}, 32'd0);
    end

    // All four change together. rr_ptr is 0, so the beats come out in
    // order 0..3 with no gaps.
    applyStimulus(0, 24'h000011, 1'b1);
    applyStimulus(1, 24'h000022, 1'b1);
    applyStimulus(2, 24'h000033, 1'b1);
    applyStimulus(3, 24'h000044, 1'b1);
    tick();
    checkOutput("all_pendSet", {28'b0, stsPending}, 32'h0000000F);
    checkOutput("all_notYet",  {31'b0, tvalid}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      tick();
      expectBeatNow("all_beat");
    end
    tick();
    checkOutput("all_idle",    {31'b0, tvalid}, 32'd0);
    checkOutput("all_pendClr", {28'b0, stsPending}, 32'd0);
    checkOutput("all_sbDrain", expQ.size(), 32'd0);

    // Single change on ch2. The beat appears two edges after the change.
    applyStimulus(2, 24'h00ABCD, 1'b1);
    tick();
    checkOutput("ch2_pend",   {28'b0, stsPending}, 32'h00000004);
    checkOutput("ch2_notYet", {31'b0, tvalid}, 32'd0);
    tick();
    expectBeatNow("ch2_beat");
    tick();
    checkOutput("ch2_idle",    {31'b0, tvalid}, 32'd0);
    checkOutput("ch2_pendClr", {28'b0, stsPending}, 32'd0);

    // Backpressure. The first beat holds while later values coalesce.
    // Only the newest value follows.
    tready = 1'b0;
    applyStimulus(1, 24'h000005, 1'b1);
    tick();
    checkOutput("bp_pend", {28'b0, stsPending}, 32'h00000002);
    tick();
    checkOutput("bp_valid", {31'b0, tvalid}, 32'd1);
    checkOutput("bp_data",  tdata, 32'h01000005);
    checkOutput("bp_grantClr", {28'b0, stsPending}, 32'd0);
    applyStimulus(1, 24'h000006, 1'b0);
    tick();
    checkOutput("bp_hold6", tdata, 32'h01000005);
    checkOutput("bp_repend", {28'b0, stsPending}, 32'h00000002);
    applyStimulus(1, 24'h000007, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("bp_holdValid", {31'b0, tvalid}, 32'd1);
      checkOutput("bp_holdData",  tdata, 32'h01000005);
    end
    tready = 1'b1;
    expectBeatNow("bp_first");
    tick();
    expectBeatNow("bp_second");
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("bp_noExtra", {31'b0, tvalid}, 32'd0);
    end

    // A masked channel stays pending and is sent once unmasked.
    cfgMask = 4'hE;
    applyStimulus(0, 24'h000009, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("mask_pend",  {28'b0, stsPending}, 32'h00000001);
      checkOutput("mask_valid", {31'b0, tvalid}, 32'd0);
    end
    cfgMask = 4'hF;
    tick();
    expectBeatNow("mask_beat");
    tick();
    checkOutput("mask_idle", {31'b0, tvalid}, 32'd0);

    // Reset during a stalled beat drops it. Afterwards every nonzero word
    // differs from the cleared shadow and is re-sent, starting from ch0.
    tready = 1'b0;
    applyStimulus(3, 24'h000007, 1'b0);
    tick();
    tick();
    checkOutput("mrst_validBefore", {31'b0, tvalid}, 32'd1);
    checkOutput("mrst_dataBefore",  tdata, 32'h03000007);
    aresetn = 1'b0;
    tick();
    checkOutput("mrst_validDrop", {31'b0, tvalid}, 32'd0);
    checkOutput("mrst_tdataClr",  tdata, 32'd0);
    checkOutput("mrst_pendClr",   {28'b0, stsPending}, 32'd0);
    aresetn = 1'b1;
    tready  = 1'b1;
    expQ.push_back(32'h00000009);
    expQ.push_back(32'h01000007);
    expQ.push_back(32'h0200ABCD);
    expQ.push_back(32'h03000007);
    tick();
    checkOutput("mrst_pendAll", {28'b0, stsPending}, 32'h0000000F);
    checkOutput("mrst_notYet",  {31'b0, tvalid}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      tick();
      expectBeatNow("mrst_resend");
    end
    tick();
    checkOutput("mrst_idle",    {31'b0, tvalid}, 32'd0);
    checkOutput("mrst_sbDrain", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
